// File: rtl/circuito_exp4_jogo.sv
// Sequence-memory game controller: a fixed 16-entry one-hot ROM sequence is
// replayed by the player on four switches; the first mismatch loses, 16 matches win.
module circuito_exp4_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogada,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_ERRO   = 4'hE
    } estado_t;

    function automatic logic [3:0] rom_jogada(input logic [3:0] addr);
        logic [3:0] v;
        case (addr)
            4'd0:    v = 4'b0001;
            4'd1:    v = 4'b0010;
            4'd2:    v = 4'b0100;
            4'd3:    v = 4'b1000;
            4'd4:    v = 4'b0100;
            4'd5:    v = 4'b0010;
            4'd6:    v = 4'b0001;
            4'd7:    v = 4'b0001;
            4'd8:    v = 4'b0010;
            4'd9:    v = 4'b0010;
            4'd10:   v = 4'b0100;
            4'd11:   v = 4'b0100;
            4'd12:   v = 4'b1000;
            4'd13:   v = 4'b1000;
            4'd14:   v = 4'b0001;
            4'd15:   v = 4'b0100;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex7seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    estado_t    r_estado;
    estado_t    w_proximo;
    logic [3:0] r_contador;
    logic [3:0] r_jogada;
    logic       r_tem_d;
    logic       w_tem;
    logic       w_jogada;
    logic       w_igual;
    logic       w_fim;
    logic       w_zera;
    logic       w_conta;
    logic       w_registra;
    logic [3:0] w_memoria;

    assign w_tem     = |chaves;
    assign w_jogada  = w_tem & ~r_tem_d;
    assign w_memoria = rom_jogada(r_contador);
    assign w_igual   = (r_jogada == w_memoria);
    assign w_fim     = (r_contador == 4'd15);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic.
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL: begin
                if (iniciar) w_proximo = PREPARACAO;
                else         w_proximo = INICIAL;
            end
            PREPARACAO: w_proximo = ESPERA;
            ESPERA: begin
                if (w_jogada) w_proximo = REGISTRA;
                else          w_proximo = ESPERA;
            end
            REGISTRA: w_proximo = COMPARACAO;
            COMPARACAO: begin
                if (!w_igual)   w_proximo = FIM_ERRO;
                else if (w_fim) w_proximo = FIM_ACERTO;
                else            w_proximo = PROXIMO;
            end
            PROXIMO: w_proximo = ESPERA;
            FIM_ACERTO: begin
                if (iniciar) w_proximo = PREPARACAO;
                else         w_proximo = FIM_ACERTO;
            end
            FIM_ERRO: begin
                if (iniciar) w_proximo = PREPARACAO;
                else         w_proximo = FIM_ERRO;
            end
            default: w_proximo = INICIAL;
        endcase
    end

    // Moore decode of datapath controls and game-status outputs.
    always_comb begin
        w_zera     = 1'b0;
        w_conta    = 1'b0;
        w_registra = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        pronto     = 1'b0;
        case (r_estado)
            PREPARACAO: w_zera     = 1'b1;
            REGISTRA:   w_registra = 1'b1;
            PROXIMO:    w_conta    = 1'b1;
            FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FIM_ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            default: begin
                w_zera     = 1'b0;
                w_conta    = 1'b0;
                w_registra = 1'b0;
            end
        endcase
    end

    // Address counter, play register and edge-detect history of the switches.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_contador <= 4'd0;
            r_jogada   <= 4'd0;
            r_tem_d    <= 1'b0;
        end else begin
            r_tem_d <= w_tem;
            if (w_zera) begin
                r_contador <= 4'd0;
                r_jogada   <= 4'd0;
            end else begin
                if (w_conta) r_contador <= r_contador + 4'd1;
                else         r_contador <= r_contador;
                if (w_registra) r_jogada <= chaves;
                else            r_jogada <= r_jogada;
            end
        end
    end

    assign leds          = r_jogada;
    assign db_igual      = w_igual;
    assign db_contagem   = hex7seg(r_contador);
    assign db_memoria    = hex7seg(w_memoria);
    assign db_estado     = hex7seg(r_estado);
    assign db_jogada     = hex7seg(r_jogada);
    assign db_clock      = clock;
    assign db_iniciar    = iniciar;
    assign db_tem_jogada = w_tem;

endmodule

// File: tb/tb_circuito_exp4_jogo.sv
// Bench for the sequence-memory game: a per-edge game model checked every cycle,
// plus hand-computed literal checks at the milestones of the game.
`timescale 1us/1ns
module tb_circuito_exp4_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'd0;
    logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogada;

    int total = 0;
    int bad = 0;

    circuito_exp4_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogada(db_jogada), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
    );

    always #500 clock = ~clock;

    function automatic logic [3:0] seq(input int i);
        logic [3:0] s [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                               4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b0001, 4'b0100};
        return s[i];
    endfunction

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase is the displayed hex code, idx is the sequence position.
    bit         m_valid = 1'b0;
    int         m_ph = 0;
    int         m_idx = 0;
    logic [3:0] m_play = 4'd0;
    bit         m_held = 1'b0;

    function automatic int next_ph(input int ph, input int idx, input logic [3:0] play,
                                   input bit start, input bit new_play);
        case (ph)
            0:          return start ? 1 : 0;
            1:          return 2;
            2:          return new_play ? 4 : 2;
            4:          return 5;
            5:          return (play != seq(idx)) ? 14 : (idx == 15 ? 10 : 6);
            6:          return 2;
            10, 14:     return start ? 1 : ph;
            default:    return 0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_valid <= 1'b1;
            m_ph    <= 0;
            m_idx   <= 0;
            m_play  <= 4'd0;
            m_held  <= 1'b0;
        end else begin
            m_held <= (chaves != 4'd0);
            m_ph   <= next_ph(m_ph, m_idx, m_play, iniciar, (chaves != 4'd0) && !m_held);
            if (m_ph == 1) begin
                m_idx  <= 0;
                m_play <= 4'd0;
            end else begin
                if (m_ph == 6) m_idx <= m_idx + 1;
                if (m_ph == 4) m_play <= chaves;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("acertou", acertou, m_ph == 10);
            check("errou", errou, m_ph == 14);
            check("pronto", pronto, m_ph == 10 || m_ph == 14);
            check("leds", leds, m_play);
            check("db_igual", db_igual, m_play == seq(m_idx));
            check("db_contagem", db_contagem, seg(m_idx));
            check("db_memoria", db_memoria, seg(int'(seq(m_idx))));
            check("db_estado", db_estado, seg(m_ph));
            check("db_jogada", db_jogada, seg(int'(m_play)));
            check("db_clock", db_clock, 1'b0);
            check("db_iniciar", db_iniciar, iniciar);
            check("db_tem_jogada", db_tem_jogada, chaves != 4'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #100;
        end
    endtask

    task automatic play(input logic [3:0] v, input int hold, input int idle);
        chaves = v;
        tick(hold);
        chaves = 4'd0;
        tick(idle);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_estado"}, db_estado, 7'b1000000);
        check({tag, "_contagem"}, db_contagem, 7'b1000000);
        check({tag, "_memoria"}, db_memoria, 7'b1111001);
        check({tag, "_jogada"}, db_jogada, 7'b1000000);
        check({tag, "_leds"}, leds, 4'b0000);
        check({tag, "_status"}, {acertou, errou, pronto}, 3'b000);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check_reset_values("reset");

        iniciar = 1'b1;
        tick(1);
        check("start_prep", db_estado, 7'b1111001);
        tick(4);
        iniciar = 1'b0;
        check("start_espera", db_estado, 7'b0100100);
        check("start_leds", leds, 4'b0000);
        check("start_cont", db_contagem, 7'b1000000);

        play(4'b0001, 10, 10);
        play(4'b0010, 10, 10);
        play(4'b0100, 10, 10);
        chaves = 4'b0001;
        tick(3);
        check("err_latency", errou, 1'b1);
        tick(2);
        chaves = 4'd0;
        tick(3);
        check("err_status", {acertou, errou, pronto}, 3'b011);
        check("err_cont", db_contagem, 7'b0110000);
        check("err_leds", leds, 4'b0001);
        check("err_mem", db_memoria, 7'b0000000);

        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(1);
        check("restart_estado", db_estado, 7'b0100100);
        check("restart_cont", db_contagem, 7'b1000000);
        check("restart_leds", leds, 4'b0000);

        for (int i = 0; i < 16; i++) play(seq(i), 4, 4);
        check("win_status", {acertou, errou, pronto}, 3'b101);
        check("win_cont", db_contagem, 7'b0001110);
        check("win_leds", leds, 4'b0100);

        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(1);
        play(4'b0001, 20, 4);
        check("hold_cont", db_contagem, 7'b1111001);
        check("hold_estado", db_estado, 7'b0100100);
        check("hold_status", pronto, 1'b0);

        chaves = 4'b0010;
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chaves = 4'd0;
        check_reset_values("midreset");
        tick(2);
        check("midreset_idle", db_estado, 7'b1000000);

        iniciar = 1'b1;
        tick(2);
        iniciar = 1'b0;
        play(4'b0011, 4, 3);
        check("multi_status", {acertou, errou, pronto}, 3'b011);
        check("multi_leds", leds, 4'b0011);
        check("multi_cont", db_contagem, 7'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
